// File: rtl/ssd_pkg.sv
// Shared constants for 7-segment display blocks: active-low segment codes,
// segment bit positions within {a..g} and the digit-index type.
package ssd_pkg;

  typedef logic [1:0] idx_t;

  localparam logic [6:0] SEG_0   = 7'h01;
  localparam logic [6:0] SEG_1   = 7'h4F;
  localparam logic [6:0] SEG_2   = 7'h12;
  localparam logic [6:0] SEG_3   = 7'h06;
  localparam logic [6:0] SEG_4   = 7'h4C;
  localparam logic [6:0] SEG_5   = 7'h24;
  localparam logic [6:0] SEG_6   = 7'h20;
  localparam logic [6:0] SEG_7   = 7'h0F;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h04;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit positions of each segment inside the 7-bit {a,b,c,d,e,f,g} vector.
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [7:0] SSD_DARK = 8'hFF;
  localparam logic [3:0] CTL_OFF  = 4'hF;

endpackage

// File: rtl/ssd_decode.sv
// BCD to active-low 7-segment decoder, {a..g}; codes 10-15 light nothing.
module ssd_decode
  import ssd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with per-frame input snapshot,
// leading-zero blanking and decimal points. Optional blink: SSD_BLINK_EN.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 65536
`ifdef SSD_BLINK_EN
  , parameter int BLINK_DIV = 128
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        lz_blank,
`ifdef SSD_BLINK_EN
  input  logic        blink,
`endif
  output logic [7:0]  D_ssd,
  output logic [3:0]  ssd_ctl,
  output logic        frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  idx_t             idx_q, idx_d;
  logic             run_q, run_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       dp_q, dp_d;
  logic             lz_q, lz_d;
  logic [7:0]       d_ssd_q, d_ssd_d;
  logic [3:0]       ssd_ctl_q, ssd_ctl_d;
  logic             frame_start_q, frame_start_d;

  logic             tick, snap, hide, blanked;
  logic             d3z, d2z, d1z;
  logic [3:0]       blank_vec, cur_digit;
  logic [6:0]       cur_seg;

`ifdef SSD_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
`endif

  ssd_decode u_decode (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  always_comb begin
    // run_q is low only on the first cycle after reset release: that cycle
    // takes the initial snapshot while the outputs stay dark.
    run_d  = 1'b1;
    tick   = run_q && (cnt_q == CNT_MAX);
    snap   = !run_q || (tick && (idx_q == 2'd3));
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    if (run_q) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) idx_d = idx_q + 2'd1;
    end

    digits_d      = digits_q;
    dp_d          = dp_q;
    lz_d          = lz_q;
    frame_start_d = snap;
    if (snap) begin
      digits_d = digits;
      dp_d     = dp_en;
      lz_d     = lz_blank;
    end

    case (idx_q)
      2'd0:    cur_digit = digits_q[3:0];
      2'd1:    cur_digit = digits_q[7:4];
      2'd2:    cur_digit = digits_q[11:8];
      default: cur_digit = digits_q[15:12];
    endcase

    d3z       = (digits_q[15:12] == 4'd0);
    d2z       = (digits_q[11:8]  == 4'd0);
    d1z       = (digits_q[7:4]   == 4'd0);
    blank_vec = {lz_q & d3z, lz_q & d3z & d2z, lz_q & d3z & d2z & d1z, 1'b0};
    blanked   = blank_vec[idx_q];

`ifdef SSD_BLINK_EN
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (tick) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
    hide = blink && phase_q;
`else
    hide = 1'b0;
`endif

    d_ssd_d   = SSD_DARK;
    ssd_ctl_d = CTL_OFF;
    if (run_q && !blanked && !hide) begin
      ssd_ctl_d = ~(4'b0001 << idx_q);
      d_ssd_d   = {cur_seg, ~dp_q[idx_q]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      run_q         <= 1'b0;
      digits_q      <= '0;
      dp_q          <= '0;
      lz_q          <= 1'b0;
      d_ssd_q       <= SSD_DARK;
      ssd_ctl_q     <= CTL_OFF;
      frame_start_q <= 1'b0;
`ifdef SSD_BLINK_EN
      bcnt_q        <= '0;
      phase_q       <= 1'b0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      run_q         <= run_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      lz_q          <= lz_d;
      d_ssd_q       <= d_ssd_d;
      ssd_ctl_q     <= ssd_ctl_d;
      frame_start_q <= frame_start_d;
`ifdef SSD_BLINK_EN
      bcnt_q        <= bcnt_d;
      phase_q       <= phase_d;
`endif
    end
  end

  assign D_ssd       = d_ssd_q;
  assign ssd_ctl     = ssd_ctl_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: edge-numbered reference model of the scan,
// snapshot, blanking and (with SSD_BLINK_EN) blink behaviour.
module tb_ssd_scan_driver;

  localparam int RD = 4;
  localparam int BD = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic        lz_i = 1'b0;
  logic        blink_i = 1'b0;
  logic [7:0]  d_ssd_o;
  logic [3:0]  ssd_ctl_o;
  logic        frame_start_o;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [15:0] m_digits = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lz = 1'b0;

  logic [6:0] seg_tab [0:15] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  // clock / reset
  always #5 clk = ~clk;

  ssd_scan_driver #(
    .REFRESH_DIV (RD)
`ifdef SSD_BLINK_EN
    , .BLINK_DIV (BD)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits_i),
    .dp_en       (dp_i),
    .lz_blank    (lz_i),
`ifdef SSD_BLINK_EN
    .blink       (blink_i),
`endif
    .D_ssd       (d_ssd_o),
    .ssd_ctl     (ssd_ctl_o),
    .frame_start (frame_start_o)
  );

  // Reference model: edge n (1 = first edge after release) is the snapshot
  // edge of a frame when (n-1) is a multiple of the frame length; from edge
  // 2 on, each digit slot shows for RD edges, one edge behind the counter.
  function automatic void expect_out(input int n, output logic [7:0] ed,
                                     output logic [3:0] ec, output logic ef);
    int   slot, idx, t;
    logic lit, hide;
    logic [3:0] dig;
    ef = ((n - 1) % FRAME) == 0;
    ed = 8'hFF;
    ec = 4'hF;
    if (n >= 2) begin
      slot = (n - 2) / RD;
      idx  = slot % 4;
      dig  = m_digits[idx*4 +: 4];
      lit  = 1'b1;
      if (m_lz && idx != 0) begin
        lit = 1'b0;
        for (int j = idx; j < 4; j++)
          if (m_digits[j*4 +: 4] != 4'd0) lit = 1'b1;
      end
      t    = slot;
      hide = 1'b0;
`ifdef SSD_BLINK_EN
      hide = blink_i && (((t / BD) % 2) == 1);
`endif
      if (lit && !hide) begin
        ec      = 4'hF;
        ec[idx] = 1'b0;
        ed      = {seg_tab[dig], ~m_dp[idx]};
      end
    end
  endfunction

  task automatic check_outputs(input logic [7:0] ed, input logic [3:0] ec, input logic ef);
    checks++;
    assert (d_ssd_o === ed) else begin
      errors++;
      $error("FAIL d_ssd edge=%0d got=%h exp=%h", edge_n, d_ssd_o, ed);
    end
    checks++;
    assert (ssd_ctl_o === ec) else begin
      errors++;
      $error("FAIL ssd_ctl edge=%0d got=%b exp=%b", edge_n, ssd_ctl_o, ec);
    end
    checks++;
    assert (frame_start_o === ef) else begin
      errors++;
      $error("FAIL frame_start edge=%0d got=%b exp=%b", edge_n, frame_start_o, ef);
    end
  endtask

  // driver: one running clock edge, expectation computed from pre-edge state
  task automatic step();
    logic [7:0] ed;
    logic [3:0] ec;
    logic       ef;
    edge_n++;
    expect_out(edge_n, ed, ec, ef);
    if (ef) begin
      m_digits = digits_i;
      m_dp     = dp_i;
      m_lz     = lz_i;
    end
    @(posedge clk);
    #1;
    check_outputs(ed, ec, ef);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic reset_cycles(input int k);
    rst_n = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      check_outputs(8'hFF, 4'hF, 1'b0);
    end
    edge_n = 0;
    rst_n  = 1'b1;
  endtask

  initial begin
    // reset
    reset_cycles(3);

    // scan of 1234
    digits_i = 16'h1234;
    run(2 * FRAME + 4);

    // tearing: change while digit 1 is being scanned
    for (int k = 0; k < FRAME && (((edge_n - 1) / RD) % 4) != 1; k++) step();
    digits_i = 16'h5678;
    run(FRAME + 8);

    // leading-zero blanking
    digits_i = 16'h0030;
    lz_i     = 1'b1;
    run(2 * FRAME + 4);
    digits_i = 16'h0000;
    run(2 * FRAME);

    // decimal point and invalid code
    digits_i = 16'hF000;
    dp_i     = 4'b0001;
    lz_i     = 1'b0;
    run(2 * FRAME + 4);

    // randomized inputs changing at arbitrary moments
    for (int r = 0; r < 12; r++) begin
      for (int j = 0; j < 4; j++)
        digits_i[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      dp_i = 4'($urandom_range(0, 15));
      lz_i = 1'($urandom_range(0, 1));
`ifdef SSD_BLINK_EN
      blink_i = 1'($urandom_range(0, 1));
`endif
      run($urandom_range(1, 24));
    end
    blink_i = 1'b0;

    // reset in the middle of a frame
    digits_i = 16'h9081;
    lz_i     = 1'b1;
    run(FRAME + 6);
    reset_cycles(2);
    run(2 * FRAME);

`ifdef SSD_BLINK_EN
    // blink on, then off
    blink_i = 1'b1;
    run(3 * FRAME);
    blink_i = 1'b0;
    run(2 * FRAME);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
